// File: rtl/cad_out_serializer.sv
// Output stage for the CAD conv/deconv engine: buffers result words in a small FIFO
// and streams each frame one bit per cycle, flagging underrun if the producer falls behind.
module cad_out_serializer #(
   parameter int DATA_W    = 20,
   parameter int DEPTH     = 4,
   parameter int LEN_W     = 10,
   parameter int MSB_FIRST = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              frame_start,
   input  logic [LEN_W-1:0]  frame_len,
   input  logic              res_valid,
   input  logic [DATA_W-1:0] res_data,
   output logic              res_ready,
   output logic              out_valid,
   output logic              out_value,
   output logic              busy,
   output logic              underrun
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam int BIT_W = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] FULL     = CNT_W'(DEPTH);
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

   typedef enum logic [1:0] {IDLE, FILL, SHIFT} state_t;

   state_t            state;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  count;
   logic [LEN_W-1:0]  in_left;
   logic [LEN_W-1:0]  out_left;
   logic [BIT_W-1:0]  bit_cnt;
   logic [DATA_W-1:0] shreg;

   logic              push;
   logic              pop;
   logic              head_avail;
   logic              fill_done;
   logic              word_end;
   logic              last_word;
   logic              start_ok;
   logic [DATA_W-1:0] head;

   // Bit that goes on the wire first from a freshly loaded word.
   function automatic logic lead_bit(input logic [DATA_W-1:0] w);
      if (MSB_FIRST != 0)
         return w[DATA_W-1];
      else
         return w[0];
   endfunction

   // Drop the bit just emitted so the next one sits at the lead position.
   function automatic logic [DATA_W-1:0] advance(input logic [DATA_W-1:0] w);
      if (MSB_FIRST != 0)
         return {w[DATA_W-2:0], 1'b0};
      else
         return {1'b0, w[DATA_W-1:1]};
   endfunction

   assign head       = mem[rd_ptr];
   assign head_avail = (count != '0);
   assign start_ok   = frame_start && (frame_len != '0);

   // Ready depends only on registered state, so a full FIFO never accepts,
   // even in a cycle where a pop is also taking place.
   assign res_ready  = (state != IDLE) && (count < FULL) && (in_left != '0);
   assign push       = res_valid && res_ready;

   assign fill_done  = (state == FILL) &&
                       ((count == FULL) || ((in_left == '0) && head_avail));
   assign word_end   = (state == SHIFT) && (bit_cnt == '0);
   assign last_word  = (out_left == LEN_W'(1));
   assign pop        = fill_done || (word_end && !last_word && head_avail);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         in_left   <= '0;
         out_left  <= '0;
         bit_cnt   <= '0;
         out_valid <= 1'b0;
         out_value <= 1'b0;
         busy      <= 1'b0;
         underrun  <= 1'b0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;

         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase

         if ((state == IDLE) && start_ok)
            in_left <= frame_len;
         else if (push)
            in_left <= in_left - 1'b1;

         case (state)
            IDLE: begin
               if (start_ok) begin
                  state    <= FILL;
                  busy     <= 1'b1;
                  out_left <= frame_len;
                  underrun <= 1'b0;
               end
            end

            FILL: begin
               if (fill_done) begin
                  state     <= SHIFT;
                  out_valid <= 1'b1;
                  out_value <= lead_bit(head);
                  bit_cnt   <= LAST_BIT;
               end
            end

            SHIFT: begin
               if (bit_cnt != '0) begin
                  out_value <= lead_bit(shreg);
                  bit_cnt   <= bit_cnt - 1'b1;
               end else begin
                  out_left <= out_left - 1'b1;
                  if (last_word) begin
                     state     <= IDLE;
                     busy      <= 1'b0;
                     out_valid <= 1'b0;
                     out_value <= 1'b0;
                  end else if (head_avail) begin
                     // Back-to-back reload keeps out_valid gap-free across words.
                     out_value <= lead_bit(head);
                     bit_cnt   <= LAST_BIT;
                  end else begin
                     state     <= FILL;
                     underrun  <= 1'b1;
                     out_valid <= 1'b0;
                     out_value <= 1'b0;
                  end
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

   // Data-only storage: contents are meaningless until qualified by count/state.
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= res_data;
      if (pop)
         shreg <= advance(head);
      else if (state == SHIFT)
         shreg <= advance(shreg);
   end

endmodule

// File: tb/tb_cad_out_serializer.sv
// Directed bench for cad_out_serializer: table of single-word frames plus
// hand-written multi-cycle sequences (burst, starvation, ignored start, reset, MSB order).
module tb_cad_out_serializer;

   localparam int DATA_W = 20;
   localparam int DEPTH  = 4;
   localparam int LEN_W  = 10;
   localparam int MAXB   = 256;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              frame_start;
   logic [LEN_W-1:0]  frame_len;
   logic              res_valid;
   logic [DATA_W-1:0] res_data;
   logic              res_ready, out_valid, out_value, busy, underrun;
   logic              m_res_ready, m_out_valid, m_out_value, m_busy, m_underrun;

   cad_out_serializer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .LEN_W(LEN_W), .MSB_FIRST(0)) dut (
      .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .frame_len(frame_len),
      .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
      .out_valid(out_valid), .out_value(out_value), .busy(busy), .underrun(underrun)
   );

   cad_out_serializer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .LEN_W(LEN_W), .MSB_FIRST(1)) dut_m (
      .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .frame_len(frame_len),
      .res_valid(res_valid), .res_data(res_data), .res_ready(m_res_ready),
      .out_valid(m_out_valid), .out_value(m_out_value), .busy(m_busy), .underrun(m_underrun)
   );

   always #5 clk = ~clk;

   typedef struct { logic v; logic [DATA_W-1:0] d; } ent_t;
   typedef struct {
      logic [DATA_W-1:0] data;
      int                ones;
      logic [3:0]        head_l;
      logic [3:0]        head_m;
      logic              last_l;
      logic              last_m;
   } vec_t;

   ent_t              pq[$];
   logic [DATA_W-1:0] exp_q[$];
   vec_t              tbl[6];

   int   checks = 0;
   int   failures = 0;
   logic fb_l[MAXB];
   logic fb_m[MAXB];
   int   f_nl, f_nm, f_runs, f_glitch, f_pushes, f_rdy, f_push_cyc, f_first_ov;
   int   f_gap_und, f_gap_bits, f_cyc, f_twin, f_pre_und;
   logic [7:0] f_rtrace;
   logic prev_ov, f_done, f_rst_hit;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_head();
      if (pq.size() > 0 && pq[0].v) begin
         res_valid = 1'b1;
         res_data  = pq[0].d;
      end else begin
         res_valid = 1'b0;
         res_data  = '0;
      end
   endtask

   task automatic clear_src();
      pq.delete();
      exp_q.delete();
   endtask

   task automatic add_word(input logic [DATA_W-1:0] w);
      pq.push_back('{v: 1'b1, d: w});
      exp_q.push_back(w);
   endtask

   task automatic add_idle(input int n);
      for (int i = 0; i < n; i++)
         pq.push_back('{v: 1'b0, d: '0});
   endtask

   // Sample outputs (1 time unit after the edge), then advance one clock.
   task automatic step();
      logic acc;
      if (out_valid) begin
         if (f_nl < MAXB) fb_l[f_nl] = out_value;
         f_nl++;
         if (!prev_ov) f_runs++;
         if (f_first_ov < 0) f_first_ov = f_cyc;
      end else if (out_value) begin
         f_glitch++;
      end
      if (m_out_valid) begin
         if (f_nm < MAXB) fb_m[f_nm] = m_out_value;
         f_nm++;
      end else if (m_out_value) begin
         f_glitch++;
      end
      if ({m_res_ready, m_out_valid, m_busy, m_underrun} !== {res_ready, out_valid, busy, underrun})
         f_twin++;
      if (prev_ov && !out_valid && busy && f_gap_und < 0) begin
         f_gap_und  = int'(underrun);
         f_gap_bits = f_nl;
      end
      prev_ov = out_valid;
      if (f_cyc < 8) f_rtrace[f_cyc[2:0]] = res_ready;
      if (res_ready) f_rdy++;
      acc = res_valid && res_ready;
      if (acc) begin
         f_pushes++;
         if (f_push_cyc < 0) f_push_cyc = f_cyc;
      end
      tick();
      f_cyc++;
      if (pq.size() > 0 && (acc || !pq[0].v)) pq.delete(0);
      drive_head();
   endtask

   task automatic run_frame(input string name, input int len, input int budget,
                            input int poke_at, input int rst_bits);
      f_nl = 0; f_nm = 0; f_runs = 0; f_glitch = 0; f_pushes = 0; f_rdy = 0;
      f_push_cyc = -1; f_first_ov = -1; f_gap_und = -1; f_gap_bits = -1;
      f_cyc = 0; f_twin = 0; f_pre_und = -1; f_rtrace = '0;
      prev_ov = 1'b0; f_done = 1'b0; f_rst_hit = 1'b0;
      drive_head();
      frame_len   = LEN_W'(len);
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      for (int k = 0; k < budget; k++) begin
         if (k == poke_at) begin
            frame_start = 1'b1;
            frame_len   = LEN_W'(3);
         end
         if (rst_bits > 0 && f_nl == rst_bits) begin
            f_pre_und = int'(underrun);
            rst_n = 1'b0;
            step();
            rst_n = 1'b1;
            pq.delete();
            drive_head();
            f_rst_hit = 1'b1;
            f_done    = 1'b1;
            break;
         end
         step();
         frame_start = 1'b0;
         if (!busy) begin
            f_done = 1'b1;
            break;
         end
      end
      chk({name, "_done"}, f_done, 1);
   endtask

   task automatic check_frame(input string name, input int len, input int runs);
      int ml = 0;
      int mm = 0;
      for (int w = 0; w < exp_q.size(); w++) begin
         logic [DATA_W-1:0] ew;
         ew = exp_q[w];
         for (int b = 0; b < DATA_W; b++) begin
            if (w * DATA_W + b < MAXB) begin
               if (fb_l[w * DATA_W + b] !== ew[b]) ml++;
               if (fb_m[w * DATA_W + b] !== ew[DATA_W-1-b]) mm++;
            end
         end
      end
      chk({name, "_bits_lsb"}, f_nl, len * DATA_W);
      chk({name, "_bits_msb"}, f_nm, len * DATA_W);
      chk({name, "_runs"}, f_runs, runs);
      chk({name, "_idle_zero"}, f_glitch, 0);
      chk({name, "_stream_lsb"}, ml, 0);
      chk({name, "_stream_msb"}, mm, 0);
      chk({name, "_twin"}, f_twin, 0);
      chk({name, "_busy_end"}, busy, 0);
   endtask

   function automatic int ones_of(input bit msb, input int n);
      int c = 0;
      for (int i = 0; i < n && i < MAXB; i++)
         if ((msb ? fb_m[i] : fb_l[i]) === 1'b1) c++;
      return c;
   endfunction

   initial begin
      tbl[0] = '{20'h00005,  2, 4'b1010, 4'b0000, 1'b0, 1'b1};
      tbl[1] = '{20'hFFFFF, 20, 4'b1111, 4'b1111, 1'b1, 1'b1};
      tbl[2] = '{20'h80001,  2, 4'b1000, 4'b1000, 1'b1, 1'b1};
      tbl[3] = '{20'h12345,  7, 4'b1010, 4'b0001, 1'b0, 1'b1};
      tbl[4] = '{20'hA5A5A, 10, 4'b0101, 4'b1010, 1'b1, 1'b0};
      tbl[5] = '{20'h00000,  0, 4'b0000, 4'b0000, 1'b0, 1'b0};

      rst_n = 1'b0; frame_start = 1'b0; frame_len = '0; res_valid = 1'b0; res_data = '0;
      repeat (3) tick();
      chk("rst_ready", res_ready, 0);
      chk("rst_out", {out_valid, out_value}, 0);
      chk("rst_busy", busy, 0);
      chk("rst_underrun", underrun, 0);
      rst_n = 1'b1;
      tick();

      for (int i = 0; i < 6; i++) begin
         string nm;
         nm = $sformatf("vec%0d", i);
         clear_src();
         add_word(tbl[i].data);
         run_frame(nm, 1, 100, -1, -1);
         check_frame(nm, 1, 1);
         chk({nm, "_ones"}, ones_of(1'b0, f_nl), tbl[i].ones);
         chk({nm, "_head_lsb"}, {fb_l[0], fb_l[1], fb_l[2], fb_l[3]}, tbl[i].head_l);
         chk({nm, "_head_msb"}, {fb_m[0], fb_m[1], fb_m[2], fb_m[3]}, tbl[i].head_m);
         chk({nm, "_last_lsb"}, fb_l[DATA_W-1], tbl[i].last_l);
         chk({nm, "_last_msb"}, fb_m[DATA_W-1], tbl[i].last_m);
         chk({nm, "_latency"}, f_first_ov - f_push_cyc, 2);
         chk({nm, "_underrun"}, underrun, 0);
      end

      clear_src();
      for (int i = 1; i <= 8; i++) add_word(DATA_W'(i));
      run_frame("burst", 8, 400, -1, -1);
      check_frame("burst", 8, 1);
      chk("burst_ready_trace", f_rtrace, 8'h2F);
      chk("burst_pushes", f_pushes, 8);
      chk("burst_ready_cycles", f_rdy, 8);
      chk("burst_underrun", underrun, 0);

      clear_src();
      add_word(20'h11111); add_word(20'h22222); add_word(20'h33333); add_word(20'h44444);
      add_idle(100);
      add_word(20'h55555); add_word(20'h66666);
      run_frame("starve", 6, 400, -1, -1);
      check_frame("starve", 6, 2);
      chk("starve_gap_underrun", f_gap_und, 1);
      chk("starve_bits_before_gap", f_gap_bits, 80);
      chk("starve_sticky", underrun, 1);

      clear_src();
      add_word(20'h0000F); add_word(20'hF0000);
      run_frame("ignore", 2, 200, 30, -1);
      check_frame("ignore", 2, 1);
      chk("ignore_clears_underrun", underrun, 0);

      frame_len   = '0;
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      chk("zero_len_busy", busy, 0);
      chk("zero_len_ready", res_ready, 0);
      repeat (3) tick();
      chk("zero_len_idle", {busy, out_valid}, 0);

      clear_src();
      add_word(20'hABCDE); add_word(20'h13579); add_word(20'h2468A); add_word(20'hFEDCB);
      add_idle(90);
      add_word(20'h0F0F0);
      run_frame("rst", 5, 400, -1, 85);
      chk("rst_mid_hit", f_rst_hit, 1);
      chk("rst_mid_underrun_before", f_pre_und, 1);
      chk("rst_mid_bits_before_gap", f_gap_bits, 80);
      chk("rst_mid_ready", res_ready, 0);
      chk("rst_mid_out", {out_valid, out_value}, 0);
      chk("rst_mid_busy", busy, 0);
      chk("rst_mid_underrun", underrun, 0);

      clear_src();
      add_word(20'h00005);
      run_frame("post_rst", 1, 100, -1, -1);
      check_frame("post_rst", 1, 1);
      chk("post_rst_head", {fb_l[0], fb_l[1], fb_l[2]}, 3'b101);
      chk("post_rst_ones", ones_of(1'b0, f_nl), 2);

      clear_src();
      add_word(20'h80000); add_word(20'h00001);
      run_frame("msb", 2, 200, -1, -1);
      check_frame("msb", 2, 1);
      chk("msb_first_bit", fb_m[0], 1);
      chk("msb_last_bit", fb_m[39], 1);
      chk("msb_ones", ones_of(1'b1, f_nm), 2);
      chk("lsb_word0_end", fb_l[19], 1);
      chk("lsb_word1_start", fb_l[20], 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/cad_out_serializer.md
Name: cad_out_serializer

Overview:
- Parametrised output stage for the CAD convolution/deconvolution engine.
- Accepts DATA_W-bit results over a valid/ready handshake and buffers them in a DEPTH-entry FIFO.
- Emits each frame as one bit per cycle on out_value, qualified by out_valid.
- Guarantees gap-free out_valid within a frame whenever the producer keeps up, and flags underrun otherwise.

Parameters:
- DATA_W, 20, result word width in bits, ≥2.
- DEPTH, 4, FIFO entries; power of 2, ≥2.
- LEN_W, 10, width of frame_len.
- MSB_FIRST, 0, bit order: 0 = LSB first, 1 = MSB first.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- frame_start  in  1  one-cycle pulse; latches frame_len.
- frame_len  in  LEN_W  number of result words in the frame.
- res_valid  in  1  producer word valid.
- res_data  in  DATA_W  producer word.
- res_ready  out  1  FIFO can accept a word this cycle.
- out_valid  out  1  out_value is valid.
- out_value  out  1  serial result bit.
- busy  out  1  frame in progress (state ≠ IDLE).
- underrun  out  1  sticky: FIFO ran empty mid-frame.

Behaviour:
- All outputs and state are registered.
- While rst_n=0 at a clock edge:
  - state=IDLE, FIFO emptied, counters=0.
  - res_ready=0, out_valid=0, out_value=0, busy=0, underrun=0.
  - Reset mid-frame discards all buffered and in-flight data.
- States: IDLE, FILL, SHIFT.
- IDLE:
  - frame_start=1 with frame_len≠0 → FILL.
  - Latch in_left=frame_len and out_left=frame_len; clear underrun.
  - frame_len=0 → stay IDLE.
  - frame_start outside IDLE is ignored.
- Push rule:
  - res_ready = (state≠IDLE) && (count<DEPTH) && (in_left≠0).
  - count is the registered FIFO occupancy.
  - Push on res_valid && res_ready; in_left decrements on each push.
  - When full, no push is accepted even if a pop happens in the same cycle.
- FILL:
  - Go to SHIFT when count==DEPTH, or when in_left==0 && count≠0.
  - The condition is evaluated on registered values.
- SHIFT entry/reload:
  - Pop the head word into the shift register; bit counter=DATA_W-1.
  - out_valid=1 from the cycle after the pop decision.
- SHIFT bit emission:
  - One bit per cycle: res bit 0 first (MSB_FIRST=0) or bit DATA_W-1 first (MSB_FIRST=1).
- SHIFT end of word (bit counter==0):
  - out_left decrements.
  - If out_left becomes 0 → IDLE; out_valid=0 next cycle.
  - Else if FIFO non-empty → pop the next word in the same cycle; next bit follows with no gap.
  - Else → underrun=1 (sticky until the next accepted frame_start or reset); out_valid=0; go to FILL.
- Simultaneous push and pop on a non-full FIFO are both honoured; count is unchanged.
- Latency: an empty FIFO with frame_len=1 and the word pushed at cycle t gives first out_valid at t+2.
- Total out_valid cycles per frame = frame_len·DATA_W.
- out_value=0 whenever out_valid=0.
- FIFO pointers wrap modulo DEPTH.
- busy=1 from the cycle after an accepted frame_start until the cycle after the last bit.

Test Plan:
- DATA_W=20, frame_len=1, push 0x00005 → out_valid high 20 cycles; bits 1,0,1 then 17 zeros; then out_valid=0, busy=0, underrun=0.
- frame_len=8, producer res_valid always 1 → exactly 160 contiguous out_valid cycles; res_ready low while count==4; underrun=0.
- frame_len=6, producer sends 4 words then stalls 100 cycles → 80 contiguous bits, then underrun=1 and out_valid=0; after the last 2 words arrive, 40 more bits stream; busy then clears.
- frame_start with frame_len=3 while busy, and frame_start with frame_len=0 in IDLE → both ignored; the current frame is unaffected and state stays IDLE respectively.
- rst_n=0 for one cycle mid-SHIFT → next cycle out_valid=0, res_ready=0, busy=0, underrun=0; a new frame_len=1 frame then works normally.
- MSB_FIRST=1, frame_len=2, words 0x80000, 0x00001 → bit stream 1, nineteen 0s, nineteen 0s, 1; 40 contiguous out_valid cycles.
